// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch stage. Holds the PC, presents it to the
// instruction memory and captures the returned word into the IF/ID register.
// Supports stall, branch/jump redirect with squash, PC wrap, target word
// alignment, halt on the syscall word and a saturating fetch counter.
module pc_fetch_unit #(
    parameter int                      PC_WIDTH    = 8,
    parameter int                      INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = 8'h00,
    parameter logic [INSTR_WIDTH-1:0]  HALT_WORD   = 32'h0000_000C
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    output logic [PC_WIDTH-1:0]     o_pc,
    input  logic [INSTR_WIDTH-1:0]  i_instruct,
    input  logic                    i_stall,
    input  logic                    i_branch_taken,
    input  logic [PC_WIDTH-1:0]     i_branch_target,
    input  logic                    i_jump,
    input  logic [PC_WIDTH-1:0]     i_jump_target,
    output logic [INSTR_WIDTH-1:0]  o_if_id_instr,
    output logic [PC_WIDTH-1:0]     o_if_id_pc_plus4,
    output logic                    o_if_id_valid,
    output logic                    o_halted,
    output logic                    o_align_err,
    output logic [15:0]             o_fetch_count
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {{(PC_WIDTH-2){1'b1}}, 2'b00};

    state_t                   r_state;
    logic [PC_WIDTH-1:0]      r_pc;
    logic [INSTR_WIDTH-1:0]   r_if_id_instr;
    logic [PC_WIDTH-1:0]      r_if_id_pc_plus4;
    logic                     r_if_id_valid;
    logic                     r_halted;
    logic                     r_align_err;
    logic [15:0]              r_fetch_count;

    logic                     w_redirect;
    logic [PC_WIDTH-1:0]      w_target;
    logic [PC_WIDTH-1:0]      w_pc_plus4;
    logic                     w_target_misaligned;

    // Redirect target selection: branch has priority over jump.
    always_comb begin
        w_redirect = i_branch_taken | i_jump;
        if (i_branch_taken) begin
            w_target = i_branch_target;
        end else begin
            w_target = i_jump_target;
        end
        w_target_misaligned = (w_target[1:0] != 2'b00);
        w_pc_plus4          = r_pc + PC_STEP;   // wraps modulo 2^PC_WIDTH
    end

    // Fetch FSM together with PC, IF/ID register, flags and fetch counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state          <= S_BOOT;
            r_pc             <= RESET_PC;
            r_if_id_instr    <= {INSTR_WIDTH{1'b0}};
            r_if_id_pc_plus4 <= {PC_WIDTH{1'b0}};
            r_if_id_valid    <= 1'b0;
            r_halted         <= 1'b0;
            r_align_err      <= 1'b0;
            r_fetch_count    <= 16'h0000;
        end else begin
            r_align_err <= 1'b0;
            case (r_state)
                S_BOOT: begin
                    // Memory needs one cycle to present the word at RESET_PC.
                    r_if_id_valid <= 1'b0;
                    r_state       <= S_RUN;
                end
                S_RUN, S_HALT: begin
                    if (w_redirect) begin
                        // Redirect beats stall and squashes the IF/ID slot.
                        r_pc          <= w_target & ALIGN_MASK;
                        r_if_id_valid <= 1'b0;
                        r_align_err   <= w_target_misaligned;
                        r_halted      <= 1'b0;
                        r_state       <= S_RUN;
                    end else if (i_stall) begin
                        r_state <= r_state;
                    end else if (r_state == S_HALT) begin
                        // Halted: PC frozen, drain the last valid word once decode accepts it.
                        r_if_id_valid <= 1'b0;
                    end else begin
                        r_if_id_instr    <= i_instruct;
                        r_if_id_pc_plus4 <= w_pc_plus4;
                        r_if_id_valid    <= 1'b1;
                        r_pc             <= w_pc_plus4;
                        if (r_fetch_count != 16'hFFFF) begin
                            r_fetch_count <= r_fetch_count + 16'd1;
                        end else begin
                            r_fetch_count <= r_fetch_count;
                        end
                        if (i_instruct == HALT_WORD) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else begin
                            r_state  <= S_RUN;
                        end
                    end
                end
                default: begin
                    r_state       <= S_BOOT;
                    r_if_id_valid <= 1'b0;
                    r_halted      <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc             = r_pc;
    assign o_if_id_instr    = r_if_id_instr;
    assign o_if_id_pc_plus4 = r_if_id_pc_plus4;
    assign o_if_id_valid    = r_if_id_valid;
    assign o_halted         = r_halted;
    assign o_align_err      = r_align_err;
    assign o_fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed bench for pc_fetch_unit with a word-addressed
// instruction memory model and a scoreboard queue of expected IF state.
module tb_pc_fetch_unit;

    localparam logic [31:0] HALT_WORD = 32'h0000_000C;

    typedef struct {
        string       tag;
        logic [7:0]  pc;
        logic        valid;
        logic [31:0] instr;
        logic [7:0]  pc4;
        logic        halted;
        logic        align;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pc;
    logic [31:0] instruct;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        jump;
    logic [7:0]  jump_target;
    logic [31:0] if_id_instr;
    logic [7:0]  if_id_pc_plus4;
    logic        if_id_valid;
    logic        halted;
    logic        align_err;
    logic [15:0] fetch_count;

    logic [31:0] mem [0:63];
    exp_t        sb_q [$];
    int          n_vec  = 0;
    int          n_fail = 0;

    pc_fetch_unit dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_pc             (pc),
        .i_instruct       (instruct),
        .i_stall          (stall),
        .i_branch_taken   (branch_taken),
        .i_branch_target  (branch_target),
        .i_jump           (jump),
        .i_jump_target    (jump_target),
        .o_if_id_instr    (if_id_instr),
        .o_if_id_pc_plus4 (if_id_pc_plus4),
        .o_if_id_valid    (if_id_valid),
        .o_halted         (halted),
        .o_align_err      (align_err),
        .o_fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    assign instruct = mem[pc[7:2]];

    function automatic logic [31:0] w(input int addr);
        return 32'hA500_0000 | 32'(addr);
    endfunction

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    // Push the expectation, advance one edge, then pop and compare.
    task automatic tick(input string tag, input logic [7:0] e_pc, input logic e_v,
                        input logic [31:0] e_instr, input logic [7:0] e_pc4,
                        input logic e_h, input logic e_a, input logic [15:0] e_cnt);
        exp_t e;
        e.tag = tag; e.pc = e_pc; e.valid = e_v; e.instr = e_instr;
        e.pc4 = e_pc4; e.halted = e_h; e.align = e_a; e.cnt = e_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk(e.tag, "pc",     {24'h0, pc},             {24'h0, e.pc});
        chk(e.tag, "valid",  {31'h0, if_id_valid},    {31'h0, e.valid});
        chk(e.tag, "instr",  if_id_instr,             e.instr);
        chk(e.tag, "pc4",    {24'h0, if_id_pc_plus4}, {24'h0, e.pc4});
        chk(e.tag, "halted", {31'h0, halted},         {31'h0, e.halted});
        chk(e.tag, "align",  {31'h0, align_err},      {31'h0, e.align});
        chk(e.tag, "count",  {16'h0, fetch_count},    {16'h0, e.cnt});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = w(i * 4);
        mem[4] = HALT_WORD;                          // syscall at 8'h10
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        jump = 1'b0; jump_target = 8'h00;

        // T1: reset, boot, sequential fetch
        tick("reset",  8'h00, 1'b0, 32'h0,  8'h00, 1'b0, 1'b0, 16'd0);
        rst = 1'b0;
        tick("boot",   8'h00, 1'b0, 32'h0,  8'h00, 1'b0, 1'b0, 16'd0);
        tick("fetch0", 8'h04, 1'b1, w(0),   8'h04, 1'b0, 1'b0, 16'd1);
        tick("fetch4", 8'h08, 1'b1, w(4),   8'h08, 1'b0, 1'b0, 16'd2);

        // T2: stall holds PC, IF/ID and counter
        stall = 1'b1;
        tick("stall1", 8'h08, 1'b1, w(4),   8'h08, 1'b0, 1'b0, 16'd2);
        tick("stall2", 8'h08, 1'b1, w(4),   8'h08, 1'b0, 1'b0, 16'd2);
        stall = 1'b0;
        tick("unstall",8'h0C, 1'b1, w(8),   8'h0C, 1'b0, 1'b0, 16'd3);

        // T3: branch during stall redirects and squashes
        stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h40;
        tick("br_stl", 8'h40, 1'b0, w(8),   8'h0C, 1'b0, 1'b0, 16'd3);
        stall = 1'b0; branch_taken = 1'b0;
        tick("br_tgt", 8'h44, 1'b1, w(64),  8'h44, 1'b0, 1'b0, 16'd4);

        // T4: jump to last word, PC wraps
        jump = 1'b1; jump_target = 8'hFC;
        tick("jmp_fc", 8'hFC, 1'b0, w(64),  8'h44, 1'b0, 1'b0, 16'd4);
        jump = 1'b0;
        tick("wrap",   8'h00, 1'b1, w(252), 8'h00, 1'b0, 1'b0, 16'd5);

        // T5: halt on syscall word, stall holds the valid slot, jump resumes
        jump = 1'b1; jump_target = 8'h10;
        tick("jmp_10", 8'h10, 1'b0, w(252), 8'h00, 1'b0, 1'b0, 16'd5);
        jump = 1'b0;
        tick("halt",   8'h14, 1'b1, HALT_WORD, 8'h14, 1'b1, 1'b0, 16'd6);
        stall = 1'b1;
        tick("hlt_stl",8'h14, 1'b1, HALT_WORD, 8'h14, 1'b1, 1'b0, 16'd6);
        stall = 1'b0;
        tick("hlt_drn",8'h14, 1'b0, HALT_WORD, 8'h14, 1'b1, 1'b0, 16'd6);
        tick("hlt_hold",8'h14,1'b0, HALT_WORD, 8'h14, 1'b1, 1'b0, 16'd6);
        jump = 1'b1; jump_target = 8'h20;
        tick("resume", 8'h20, 1'b0, HALT_WORD, 8'h14, 1'b0, 1'b0, 16'd6);
        jump = 1'b0;
        tick("run20",  8'h24, 1'b1, w(32),  8'h24, 1'b0, 1'b0, 16'd7);

        // T6: misaligned branch wins over jump, align pulse for one cycle
        branch_taken = 1'b1; branch_target = 8'h43; jump = 1'b1; jump_target = 8'h80;
        tick("misalgn",8'h40, 1'b0, w(32),  8'h24, 1'b0, 1'b1, 16'd7);
        branch_taken = 1'b0; jump = 1'b0;
        tick("algn_clr",8'h44,1'b1, w(64),  8'h44, 1'b0, 1'b0, 16'd8);
        stall = 1'b1;
        tick("stl_pre",8'h44, 1'b1, w(64),  8'h44, 1'b0, 1'b0, 16'd8);
        rst = 1'b1;
        tick("rst_stl",8'h00, 1'b0, 32'h0,  8'h00, 1'b0, 1'b0, 16'd0);
        rst = 1'b0; stall = 1'b0;
        tick("reboot", 8'h00, 1'b0, 32'h0,  8'h00, 1'b0, 1'b0, 16'd0);
        tick("refetch",8'h04, 1'b1, w(0),   8'h04, 1'b0, 1'b0, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
